// File: rtl/pe_row_pkg.sv
// Shared constants and helpers for the weight-stationary PE row.
package pe_row_pkg;

  localparam int unsigned MODE_CAST_BIT = 0;
  localparam int unsigned MODE_ACC_BIT  = 1;

  localparam int unsigned DEF_NUM_PE    = 16;
  localparam int unsigned DEF_PIX_W     = 8;
  localparam int unsigned DEF_ACC_W     = 24;
  localparam int unsigned DEF_CAST_BASE = 3;
  localparam int unsigned DEF_CAST_NUM  = 3;
  localparam int unsigned DEF_ACC_LEN   = 9;

  // Signed add clamped to the range of a w-bit two's complement value (w <= 62).
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int unsigned        w);
    logic signed [63:0] sum;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sum = a + b;
    hi  = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo  = -hi - 64'sd1;
    if (sum > hi) begin
      return hi;
    end else if (sum < lo) begin
      return lo;
    end
    return sum;
  endfunction

endpackage

// File: rtl/pe_row_cfg_lane.sv
// One MAC lane: weight register, optional cast mux, multiplier, saturating accumulator.
module pe_lane
  import pe_row_pkg::*;
#(
  parameter int unsigned PIX_W   = DEF_PIX_W,
  parameter int unsigned ACC_W   = DEF_ACC_W,
  parameter bit          CAST_EN = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 w_load,
  input  logic [PIX_W-1:0]     weight_in,
  input  logic [PIX_W-1:0]     pixel,
  input  logic [PIX_W-1:0]     pixel_cast,
  input  logic                 cast_sel,
  input  logic                 accept,
  input  logic                 fresh,
  input  logic                 clear,
  output logic [2*PIX_W-1:0]   product,
  output logic [ACC_W-1:0]     psum
);

  logic                      use_cast_c;
  logic signed [PIX_W-1:0]   op_c;
  logic signed [PIX_W-1:0]   w_q, w_d;
  logic signed [2*PIX_W-1:0] prod_c;
  logic signed [ACC_W-1:0]   prod_ext_c;
  logic signed [63:0]        sum_c;
  logic signed [2*PIX_W-1:0] product_q, product_d;
  logic signed [ACC_W-1:0]   psum_q, psum_d;

  assign use_cast_c = cast_sel && CAST_EN;
  assign op_c       = use_cast_c ? pixel_cast : pixel;
  assign prod_c     = (2*PIX_W)'(op_c) * (2*PIX_W)'(w_q);
  assign prod_ext_c = ACC_W'(prod_c);
  assign sum_c      = sat_add(64'(psum_q), 64'(prod_ext_c), ACC_W);

  // Next weight, product and partial sum; the product always uses the pre-load weight.
  always_comb begin
    w_d       = w_q;
    product_d = product_q;
    psum_d    = psum_q;
    if (w_load) begin
      w_d = weight_in;
    end
    if (accept) begin
      product_d = prod_c;
      psum_d    = fresh ? prod_ext_c : ACC_W'(sum_c);
    end else if (clear) begin
      psum_d = '0;
    end
  end

  // Lane state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_q       <= '0;
      product_q <= '0;
      psum_q    <= '0;
    end else begin
      w_q       <= w_d;
      product_q <= product_d;
      psum_q    <= psum_d;
    end
  end

  assign product = product_q;
  assign psum    = psum_q;

endmodule

// File: rtl/pe_row_cfg.sv
// Row of NUM_PE MAC lanes with valid/ready handshake, window counter and systolic pixel forward.
module pe_row_cfg
  import pe_row_pkg::*;
#(
  parameter int unsigned NUM_PE    = DEF_NUM_PE,
  parameter int unsigned PIX_W     = DEF_PIX_W,
  parameter int unsigned ACC_W     = DEF_ACC_W,
  parameter int unsigned CAST_BASE = DEF_CAST_BASE,
  parameter int unsigned CAST_NUM  = DEF_CAST_NUM,
  parameter int unsigned ACC_LEN   = DEF_ACC_LEN
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [1:0]                        mode,
  input  logic                              w_load,
  input  logic [NUM_PE-1:0][PIX_W-1:0]      weight_in,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [NUM_PE-1:0][PIX_W-1:0]      pixel,
  input  logic [CAST_NUM-1:0][PIX_W-1:0]    pixel_cast,
  input  logic                              acc_clear,
  input  logic                              out_ready,
  output logic                              out_valid,
  output logic [NUM_PE-1:0][2*PIX_W-1:0]    product,
  output logic [NUM_PE-1:0][ACC_W-1:0]      psum,
  output logic [NUM_PE-1:0][PIX_W-1:0]      next_pixel,
  output logic                              next_valid,
  output logic [$clog2(ACC_LEN+1)-1:0]      acc_cnt
);

  localparam int unsigned CNT_W = $clog2(ACC_LEN + 1);

  logic                         accept_c;
  logic                         ov_hold_c;
  logic                         fresh_c;
  logic                         clr_psum_c;
  logic [CNT_W-1:0]             cnt_inc_c;
  logic [CNT_W-1:0]             acc_cnt_q, acc_cnt_d;
  logic                         out_valid_q, out_valid_d;
  logic                         next_valid_q, next_valid_d;
  logic [NUM_PE-1:0][PIX_W-1:0] next_pixel_q, next_pixel_d;

  assign in_ready   = !out_valid_q || out_ready;
  assign accept_c   = in_valid && in_ready;
  assign ov_hold_c  = out_valid_q && !out_ready;
  assign fresh_c    = !mode[MODE_ACC_BIT] || acc_clear || (acc_cnt_q == '0);
  assign clr_psum_c = acc_clear && !accept_c && !ov_hold_c;

  // Window counter, result-valid and forward-pixel next state.
  always_comb begin
    acc_cnt_d    = acc_cnt_q;
    out_valid_d  = ov_hold_c;
    next_valid_d = accept_c;
    next_pixel_d = next_pixel_q;
    cnt_inc_c    = (acc_clear ? '0 : acc_cnt_q) + CNT_W'(1);
    if (accept_c) begin
      next_pixel_d = pixel;
      if (!mode[MODE_ACC_BIT]) begin
        acc_cnt_d   = '0;
        out_valid_d = 1'b1;
      end else if (cnt_inc_c == CNT_W'(ACC_LEN)) begin
        acc_cnt_d   = '0;
        out_valid_d = 1'b1;
      end else begin
        acc_cnt_d   = cnt_inc_c;
        out_valid_d = 1'b0;
      end
    end else if (acc_clear) begin
      acc_cnt_d = '0;
    end
  end

  // Row control registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_cnt_q    <= '0;
      out_valid_q  <= 1'b0;
      next_valid_q <= 1'b0;
      next_pixel_q <= '0;
    end else begin
      acc_cnt_q    <= acc_cnt_d;
      out_valid_q  <= out_valid_d;
      next_valid_q <= next_valid_d;
      next_pixel_q <= next_pixel_d;
    end
  end

  // Lane array; only lanes inside the cast window get the broadcast operand.
  for (genvar i = 0; i < NUM_PE; i++) begin : g_lane
    localparam bit          IS_CAST = (i >= CAST_BASE) && (i < CAST_BASE + CAST_NUM);
    localparam int unsigned CIDX    = IS_CAST ? (i - CAST_BASE) : 0;

    pe_lane #(
      .PIX_W   (PIX_W),
      .ACC_W   (ACC_W),
      .CAST_EN (IS_CAST)
    ) u_lane (
      .clk        (clk),
      .rst        (rst),
      .w_load     (w_load),
      .weight_in  (weight_in[i]),
      .pixel      (pixel[i]),
      .pixel_cast (pixel_cast[CIDX]),
      .cast_sel   (mode[MODE_CAST_BIT]),
      .accept     (accept_c),
      .fresh      (fresh_c),
      .clear      (clr_psum_c),
      .product    (product[i]),
      .psum       (psum[i])
    );
  end

  assign out_valid  = out_valid_q;
  assign next_valid = next_valid_q;
  assign next_pixel = next_pixel_q;
  assign acc_cnt    = acc_cnt_q;

endmodule

// File: tb/tb_pe_row_cfg.sv
// Self-checking bench for pe_row_cfg against a beat-level behavioural model.
module tb_pe_row_cfg;

  localparam int NUM_PE    = 16;
  localparam int PIX_W     = 8;
  localparam int ACC_W     = 16;
  localparam int CAST_BASE = 3;
  localparam int CAST_NUM  = 3;
  localparam int ACC_LEN   = 9;
  localparam int CNT_W     = $clog2(ACC_LEN + 1);
  localparam int MAXV      = (1 << (ACC_W - 1)) - 1;
  localparam int MINV      = -(1 << (ACC_W - 1));

  typedef logic [NUM_PE-1:0][PIX_W-1:0]   vec8_t;
  typedef logic [NUM_PE-1:0][2*PIX_W-1:0] vecp_t;
  typedef logic [NUM_PE-1:0][ACC_W-1:0]   veca_t;

  logic                          clk = 1'b0;
  logic                          rst;
  logic [1:0]                    mode;
  logic                          w_load;
  vec8_t                         weight_in;
  logic                          in_valid;
  logic                          in_ready;
  vec8_t                         pixel;
  logic [CAST_NUM-1:0][PIX_W-1:0] pixel_cast;
  logic                          acc_clear;
  logic                          out_ready;
  logic                          out_valid;
  vecp_t                         product;
  veca_t                         psum;
  vec8_t                         next_pixel;
  logic                          next_valid;
  logic [CNT_W-1:0]              acc_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state
  int    m_w    [NUM_PE];
  int    m_prod [NUM_PE];
  int    m_psum [NUM_PE];
  vec8_t m_np;
  int    m_cnt;
  bit    m_ov;
  bit    m_nv;

  pe_row_cfg #(
    .NUM_PE(NUM_PE), .PIX_W(PIX_W), .ACC_W(ACC_W),
    .CAST_BASE(CAST_BASE), .CAST_NUM(CAST_NUM), .ACC_LEN(ACC_LEN)
  ) dut (
    .clk(clk), .rst(rst), .mode(mode), .w_load(w_load), .weight_in(weight_in),
    .in_valid(in_valid), .in_ready(in_ready), .pixel(pixel), .pixel_cast(pixel_cast),
    .acc_clear(acc_clear), .out_ready(out_ready), .out_valid(out_valid),
    .product(product), .psum(psum), .next_pixel(next_pixel),
    .next_valid(next_valid), .acc_cnt(acc_cnt)
  );

  always #5 clk = ~clk;

  function automatic int sx(input logic [PIX_W-1:0] v);
    return int'($signed(v));
  endfunction

  function automatic int sat(input int v);
    if (v > MAXV) return MAXV;
    if (v < MINV) return MINV;
    return v;
  endfunction

  function automatic vecp_t exp_prod();
    vecp_t r;
    for (int i = 0; i < NUM_PE; i++) r[i] = (2*PIX_W)'(m_prod[i]);
    return r;
  endfunction

  function automatic veca_t exp_psum();
    veca_t r;
    for (int i = 0; i < NUM_PE; i++) r[i] = ACC_W'(m_psum[i]);
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_PE; i++) begin
      m_w[i] = 0; m_prod[i] = 0; m_psum[i] = 0;
    end
    m_np = '0; m_cnt = 0; m_ov = 0; m_nv = 0;
  endtask

  // Advance the model by one clock using the currently driven inputs.
  task automatic model_step();
    bit hold, acc, fresh, complete;
    int beats, op, p;
    hold = m_ov && !out_ready;
    acc  = in_valid && (!m_ov || out_ready);
    if (acc) begin
      if (!mode[1]) begin
        fresh = 1; beats = 0; complete = 1;
      end else begin
        fresh    = acc_clear || (m_cnt == 0);
        beats    = fresh ? 1 : m_cnt + 1;
        complete = (beats == ACC_LEN);
      end
      for (int i = 0; i < NUM_PE; i++) begin
        if (mode[0] && i >= CAST_BASE && i < CAST_BASE + CAST_NUM) op = sx(pixel_cast[i - CAST_BASE]);
        else op = sx(pixel[i]);
        p = op * m_w[i];
        m_prod[i] = p;
        m_psum[i] = fresh ? p : sat(m_psum[i] + p);
      end
      m_cnt = complete ? 0 : beats;
      m_ov  = complete;
      m_np  = pixel;
      m_nv  = 1;
    end else begin
      m_nv = 0;
      m_ov = hold;
      if (acc_clear) begin
        m_cnt = 0;
        if (!hold) for (int i = 0; i < NUM_PE; i++) m_psum[i] = 0;
      end
    end
    if (w_load) for (int i = 0; i < NUM_PE; i++) m_w[i] = sx(weight_in[i]);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    mode = 2'b00; w_load = 0; in_valid = 0; acc_clear = 0; out_ready = 1;
  endtask

  task automatic load_weights(input int v);
    set_idle();
    for (int i = 0; i < NUM_PE; i++) weight_in[i] = PIX_W'(v);
    w_load = 1;
    tick();
    w_load = 0;
  endtask

  task automatic test_reset();
    rst = 1; set_idle(); weight_in = '0; pixel = '0; pixel_cast = '0;
    model_reset();
    #2;
    n_cmp++;
    if ({out_valid, next_valid, acc_cnt, |product, |psum, |next_pixel} !== '0) begin
      n_fail++; $display("FAIL reset_outputs got ov=%b nv=%b cnt=%0d prod=%h psum=%h np=%h want all 0",
                         out_valid, next_valid, acc_cnt, product, psum, next_pixel);
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    @(negedge clk); rst = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    load_weights(2);
    mode = 2'b00; in_valid = 1;
    for (int i = 0; i < NUM_PE; i++) pixel[i] = PIX_W'(i);
    tick();
    in_valid = 0;
    n_cmp++;
    if (product !== exp_prod() || product[5] !== 16'd10) begin
      n_fail++; $display("FAIL basic_product got %h want %h", product, exp_prod());
    end
    n_cmp++;
    if (psum !== exp_psum() || psum[7] !== 16'd14) begin
      n_fail++; $display("FAIL basic_psum got %h want %h", psum, exp_psum());
    end
    n_cmp++;
    if (out_valid !== 1'b1 || next_valid !== 1'b1 || acc_cnt !== '0) begin
      n_fail++; $display("FAIL basic_flags got ov=%b nv=%b cnt=%0d want 1 1 0", out_valid, next_valid, acc_cnt);
    end
    n_cmp++;
    if (next_pixel !== pixel) begin
      n_fail++; $display("FAIL basic_next_pixel got %h want %h", next_pixel, m_np);
    end
    tick();
    n_cmp++;
    if (out_valid !== 1'b0 || next_valid !== 1'b0) begin
      n_fail++; $display("FAIL basic_drain got ov=%b nv=%b want 0 0", out_valid, next_valid);
    end
  endtask

  task automatic test_cast();
    load_weights(1);
    mode = 2'b01; in_valid = 1;
    for (int i = 0; i < NUM_PE; i++) pixel[i] = 8'd5;
    pixel_cast[0] = 8'd7; pixel_cast[1] = 8'd8; pixel_cast[2] = 8'd9;
    tick();
    in_valid = 0;
    n_cmp++;
    if (product !== exp_prod() || product[3] !== 16'd7 || product[5] !== 16'd9 || product[6] !== 16'd5) begin
      n_fail++; $display("FAIL cast_product got %h want %h", product, exp_prod());
    end
    n_cmp++;
    if (next_pixel !== m_np || next_pixel[4] !== 8'd5) begin
      n_fail++; $display("FAIL cast_next_pixel got %h want %h", next_pixel, m_np);
    end
    tick();
  endtask

  task automatic test_accumulate();
    load_weights(3);
    mode = 2'b10; in_valid = 1;
    for (int i = 0; i < NUM_PE; i++) pixel[i] = 8'd4;
    for (int k = 0; k < ACC_LEN; k++) begin
      acc_clear = (k == 0);
      tick();
      n_cmp++;
      if (out_valid !== (k == ACC_LEN - 1) || acc_cnt !== CNT_W'((k + 1) % ACC_LEN)) begin
        n_fail++; $display("FAIL acc_beat%0d got ov=%b cnt=%0d want ov=%b cnt=%0d",
                           k, out_valid, acc_cnt, (k == ACC_LEN - 1), (k + 1) % ACC_LEN);
      end
    end
    in_valid = 0; acc_clear = 0;
    n_cmp++;
    if (psum !== exp_psum() || psum[0] !== 16'd108) begin
      n_fail++; $display("FAIL acc_psum got %h want %h", psum, exp_psum());
    end
    tick();
  endtask

  task automatic test_saturation();
    load_weights(127);
    mode = 2'b10; in_valid = 1;
    for (int i = 0; i < NUM_PE; i++) pixel[i] = 8'd127;
    for (int k = 0; k < 3; k++) begin
      acc_clear = (k == 0);
      tick();
    end
    in_valid = 0; acc_clear = 0;
    n_cmp++;
    if (psum !== exp_psum() || psum[7] !== 16'h7fff) begin
      n_fail++; $display("FAIL sat_psum got %h want %h", psum, exp_psum());
    end
    acc_clear = 1;
    tick();
    acc_clear = 0;
    n_cmp++;
    if (psum !== '0 || acc_cnt !== '0) begin
      n_fail++; $display("FAIL clear_idle got psum=%h cnt=%0d want 0 0", psum, acc_cnt);
    end
  endtask

  task automatic test_backpressure();
    vecp_t held;
    load_weights(-3);
    mode = 2'b00; in_valid = 1;
    for (int i = 0; i < NUM_PE; i++) pixel[i] = PIX_W'($urandom);
    tick();
    held = exp_prod();
    out_ready = 0;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < NUM_PE; i++) pixel[i] = PIX_W'($urandom);
      #1;
      n_cmp++;
      if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready got %b want 0", in_ready); end
      tick();
      n_cmp++;
      if (product !== held || out_valid !== 1'b1 || next_valid !== 1'b0) begin
        n_fail++; $display("FAIL bp_hold got prod=%h ov=%b nv=%b want prod=%h ov=1 nv=0",
                           product, out_valid, next_valid, held);
      end
    end
    out_ready = 1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready got %b want 1", in_ready); end
    tick();
    n_cmp++;
    if (product !== exp_prod() || next_valid !== 1'b1 || next_pixel !== m_np) begin
      n_fail++; $display("FAIL bp_accept got prod=%h nv=%b want prod=%h nv=1", product, next_valid, exp_prod());
    end
    in_valid = 0;
    tick();
  endtask

  task automatic test_simultaneous();
    load_weights(2);
    mode = 2'b10; in_valid = 1;
    for (int k = 0; k < 4; k++) begin
      acc_clear = (k == 0);
      for (int i = 0; i < NUM_PE; i++) pixel[i] = PIX_W'($urandom);
      tick();
    end
    acc_clear = 1;
    for (int i = 0; i < NUM_PE; i++) pixel[i] = PIX_W'($urandom);
    tick();
    acc_clear = 0;
    n_cmp++;
    if (acc_cnt !== CNT_W'(1) || psum !== exp_psum()) begin
      n_fail++; $display("FAIL clear_accept got cnt=%0d psum=%h want cnt=1 psum=%h", acc_cnt, psum, exp_psum());
    end
    mode = 2'b00; w_load = 1;
    for (int i = 0; i < NUM_PE; i++) begin weight_in[i] = 8'd5; pixel[i] = 8'd3; end
    tick();
    w_load = 0;
    n_cmp++;
    if (product !== exp_prod() || product[0] !== 16'd6) begin
      n_fail++; $display("FAIL wload_old_weight got %h want %h", product, exp_prod());
    end
    tick();
    in_valid = 0;
    n_cmp++;
    if (product !== exp_prod() || product[0] !== 16'd15) begin
      n_fail++; $display("FAIL wload_new_weight got %h want %h", product, exp_prod());
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      mode      = {($urandom_range(3) != 0), 1'($urandom)};
      in_valid  = ($urandom_range(9) < 7);
      out_ready = ($urandom_range(9) < 7);
      acc_clear = ($urandom_range(9) == 0);
      w_load    = ($urandom_range(9) < 2);
      for (int i = 0; i < NUM_PE; i++) begin
        pixel[i]     = PIX_W'($urandom);
        weight_in[i] = PIX_W'($urandom);
      end
      for (int i = 0; i < CAST_NUM; i++) pixel_cast[i] = PIX_W'($urandom);
      #1;
      n_cmp++;
      if (in_ready !== (!m_ov || out_ready)) begin
        n_fail++; $display("FAIL rnd%0d in_ready got %b want %b", c, in_ready, (!m_ov || out_ready));
      end
      tick();
      n_cmp++;
      if (product !== exp_prod()) begin
        n_fail++; $display("FAIL rnd%0d product got %h want %h", c, product, exp_prod());
      end
      n_cmp++;
      if (psum !== exp_psum()) begin
        n_fail++; $display("FAIL rnd%0d psum got %h want %h", c, psum, exp_psum());
      end
      n_cmp++;
      if (out_valid !== m_ov || next_valid !== m_nv || acc_cnt !== CNT_W'(m_cnt)) begin
        n_fail++; $display("FAIL rnd%0d flags got ov=%b nv=%b cnt=%0d want ov=%b nv=%b cnt=%0d",
                           c, out_valid, next_valid, acc_cnt, m_ov, m_nv, m_cnt);
      end
      n_cmp++;
      if (next_pixel !== m_np) begin
        n_fail++; $display("FAIL rnd%0d next_pixel got %h want %h", c, next_pixel, m_np);
      end
    end
    set_idle();
    tick();
  endtask

  task automatic test_reset_mid();
    load_weights(1);
    mode = 2'b10; in_valid = 1;
    for (int i = 0; i < NUM_PE; i++) pixel[i] = 8'd9;
    for (int k = 0; k < 3; k++) begin
      acc_clear = (k == 0);
      tick();
    end
    acc_clear = 0; in_valid = 0;
    @(negedge clk); #2;
    rst = 1;
    model_reset();
    #1;
    n_cmp++;
    if ({out_valid, next_valid, acc_cnt, |product, |psum, |next_pixel} !== '0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_mid got ov=%b nv=%b cnt=%0d psum=%h rdy=%b want zeros and rdy=1",
                         out_valid, next_valid, acc_cnt, psum, in_ready);
    end
    @(negedge clk); rst = 0;
    mode = 2'b10; in_valid = 1;
    for (int i = 0; i < NUM_PE; i++) pixel[i] = 8'd9;
    @(posedge clk); #1;
    set_idle();
    model_step();
    n_cmp++;
    if (psum !== '0 || acc_cnt !== CNT_W'(1)) begin
      n_fail++; $display("FAIL reset_weights got psum=%h cnt=%0d want psum=0 cnt=1", psum, acc_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_cast();
    test_accumulate();
    test_saturation();
    test_backpressure();
    test_simultaneous();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pe_row_cfg.md
Name: pe_row_cfg

Overview:
Parametrised, weight-stationary row of NUM_PE signed MAC lanes for the DLA convolution array. It is the successor of the fixed 16-lane row with three hard-wired cast lanes. This version adds the following:
- configurable lane count, widths and cast window;
- latched weights;
- a valid/ready handshake with backpressure;
- per-lane saturating accumulation over ACC_LEN beats.

Rows chain systolically through next_pixel/next_valid and share one stall signal.

Parameters:
NUM_PE, 16, lanes per row
PIX_W, 8, pixel and weight width (signed two's complement)
ACC_W, 24, accumulator/psum width (signed), must be >= 2*PIX_W
CAST_BASE, 3, index of first cast-capable lane
CAST_NUM, 3, number of cast-capable lanes (CAST_BASE+CAST_NUM <= NUM_PE)
ACC_LEN, 9, beats per accumulation window (>= 1)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
mode  in  2  [0] cast select, [1] accumulate enable; sampled on accepted beat
w_load  in  1  latch weight_in into all lane weight registers
weight_in  in  NUM_PE x PIX_W  weights
in_valid  in  1  pixel beat valid
in_ready  out  1  row can accept beat
pixel  in  NUM_PE x PIX_W  lane pixels
pixel_cast  in  CAST_NUM x PIX_W  broadcast pixels for cast lanes
acc_clear  in  1  restart accumulation window
out_ready  in  1  downstream accepts result
out_valid  out  1  product/psum valid
product  out  NUM_PE x 2*PIX_W  signed per-lane product of last accepted beat
psum  out  NUM_PE x ACC_W  signed per-lane accumulated sum
next_pixel  out  NUM_PE x PIX_W  registered raw pixel to next row
next_valid  out  1  one-cycle strobe after each accepted beat
acc_cnt  out  $clog2(ACC_LEN+1)  beats in current window

Behaviour:
- Reset (async) has the following effect:
  - all outputs, weight registers, accumulators and acc_cnt go to 0;
  - in_ready = 1 after release;
  - a reset mid-window discards partial sums.
- Accept condition: in_valid && in_ready, where in_ready = !out_valid || out_ready (single output stage, no skid).
- Weights:
  - w_load writes the weight registers at the clock edge.
  - If w_load and an accept occur in the same cycle, the beat uses the OLD weights.
- Lane operand:
  - Lane i in [CAST_BASE, CAST_BASE+CAST_NUM) uses pixel_cast[i-CAST_BASE] when mode[0]=1.
  - All other cases use pixel[i].
  - next_pixel always carries raw pixel[i], never the cast value.
- Latency: 1 cycle. On the edge that accepts beat k:
  - product[i] <= operand*weight (full 2*PIX_W signed);
  - next_pixel <= pixel;
  - next_valid = 1 for exactly the following cycle.
- Non-accumulate beat (mode[1]=0):
  - psum[i] <= sign-extended product;
  - out_valid <= 1;
  - acc_cnt <= 0.
- Accumulate beat (mode[1]=1):
  - psum[i] <= sat(psum[i] + product), saturating to [-2^(ACC_W-1), 2^(ACC_W-1)-1];
  - acc_cnt increments.
  - When acc_cnt reaches ACC_LEN, out_valid <= 1 and acc_cnt <= 0.
  - The first beat of a window (acc_cnt=0) loads psum = product rather than adding.
- out_valid holds, with product/psum stable, until out_ready. It then clears unless another completing beat is accepted in the same cycle.
- acc_clear:
  - With no accept: acc_cnt <= 0, psum <= 0.
  - With an accept in the same cycle: the beat starts a fresh window (psum = product, acc_cnt = 1).
  - acc_clear has no effect on a pending out_valid result.
- Mode change: if an accepted beat has mode[1]=0 while acc_cnt != 0, the partial window is discarded and the beat is treated as non-accumulate.
- Backpressure: next_valid pulses only on accept, so downstream rows stall coherently via the shared out_ready/in_ready chain.
- Sign rules: all arithmetic is signed. With PIX_W=8, -128*-128 = 16384 fits in 16 bits.

Decomposition:
- Package pe_row_pkg holds:
  - the mode bit constants (MODE_CAST_BIT=0, MODE_ACC_BIT=1);
  - default widths;
  - a sat_add function.
- Sub-module pe_lane (one lane) contains the weight register, cast mux, multiplier and saturating accumulator, with a CAST_EN parameter.
- The row instantiates NUM_PE lanes via generate and owns the handshake, acc_cnt and next_valid.

Test Plan:
- Basic products: w_load weights all 2, mode=00, pixel[i]=i, one beat → next cycle product[i]=2i, psum[i]=2i, out_valid=1, next_pixel[i]=i.
- Cast window: mode=01, pixel all 5, pixel_cast={7,8,9}, weights 1 → product[3..5]={7,8,9}, others 5, next_pixel all 5.
- Accumulation: mode=10, ACC_LEN=9, weight 3, pixel 4 for 9 beats → out_valid only after 9th beat, psum=108, acc_cnt back to 0.
- Saturation: ACC_W=16, weight 127, pixel 127 for 3 beats in acc mode → psum=32767 (not wrapped).
- Backpressure: out_ready=0 with result pending, in_valid=1 → in_ready=0; outputs stable, no next_valid. Raising out_ready for one cycle → next beat accepted in the same cycle.
- Simultaneous events:
  - acc_clear with accept at acc_cnt=4 → psum=product of that beat, acc_cnt=1.
  - w_load with accept → product uses old weights.
  - Async rst mid-window → all outputs 0 immediately.
